// File: rtl/fir_mac_nch.sv
// fir_mac_nch: one coefficient ROM stream shared by NUM_CH channel MACs. The sample
// stream comes from a circular queue. Each pass produces scaled, saturated results.
// Latency: out_vld rises 2 cycles after the first cycle in which seq is low.
// Backpressure: none. The queue paces the pass with seq, and seq is ignored outside IDLE/PRIME/ACC.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   seq               high while the queue streams one sample per cycle
//   smp_in            NUM_CH packed signed samples, channel c at [c*DATA_W +: DATA_W]
//   coef_addr         registered coefficient ROM address
//   coef_in           signed ROM data, valid one cycle after coef_addr
//   smp_out, out_vld  packed saturated results and their one-cycle valid pulse
//   busy              high whenever the engine is not in IDLE
//   tap_cnt           MACs performed in the current or last pass
//   ovr               sticky overrun flag, cleared at pass start
//
// Optional build macro: FIR_MAC_ROUND_EN selects round-half-up ahead of the
// output shift. Without it, the shift truncates.

module fir_mac_nch #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int GUARD_W    = 4,
  parameter int FRAC_SHIFT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     seq,
  input  logic [NUM_CH*DATA_W-1:0] smp_in,
  output logic [ADDR_W-1:0]        coef_addr,
  input  logic [COEF_W-1:0]        coef_in,
  output logic [NUM_CH*DATA_W-1:0] smp_out,
  output logic                     out_vld,
  output logic                     busy,
  output logic [ADDR_W:0]          tap_cnt,
  output logic                     ovr
);

  localparam int PROD_W = COEF_W + DATA_W;
  localparam int ACC_W  = DATA_W + COEF_W + GUARD_W;

  // A full ROM's worth of taps. Reaching this count with seq still high is an overrun.
  localparam logic [ADDR_W:0] MAX_TAPS = {1'b1, {ADDR_W{1'b0}}};

  // Output clamp limits, expressed at accumulator width for direct comparison.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

`ifdef FIR_MAC_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_K =
    {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_SHIFT-1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_ACC,
    S_OUT
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         coef_addr_q, coef_addr_d;
  logic [ADDR_W:0]           tap_cnt_q, tap_cnt_d;
  logic                      ovr_q, ovr_d;
  logic [NUM_CH*DATA_W-1:0]  smp_out_q, smp_out_d;
  logic                      out_vld_q, out_vld_d;
  logic signed [ACC_W-1:0]   acc_q [NUM_CH];
  logic signed [ACC_W-1:0]   acc_d [NUM_CH];

  logic signed [PROD_W-1:0]  prod     [NUM_CH];
  logic signed [ACC_W-1:0]   prod_ext [NUM_CH];
  logic signed [ACC_W-1:0]   biased   [NUM_CH];
  logic signed [ACC_W-1:0]   shifted  [NUM_CH];
  logic        [DATA_W-1:0]  sat      [NUM_CH];

  // Per-channel datapath: the product feeds the MAC, and the scale-and-clamp path feeds OUT.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      prod[c]     = PROD_W'($signed(coef_in)) *
                    PROD_W'($signed(smp_in[c*DATA_W +: DATA_W]));
      prod_ext[c] = {{GUARD_W{prod[c][PROD_W-1]}}, prod[c]};
`ifdef FIR_MAC_ROUND_EN
      biased[c]   = acc_q[c] + RND_K;
`else
      biased[c]   = acc_q[c];
`endif
      shifted[c]  = biased[c] >>> FRAC_SHIFT;
      if (shifted[c] > SAT_MAX) begin
        sat[c] = SAT_MAX[DATA_W-1:0];
      end else if (shifted[c] < SAT_MIN) begin
        sat[c] = SAT_MIN[DATA_W-1:0];
      end else begin
        sat[c] = shifted[c][DATA_W-1:0];
      end
    end
  end

  // Next-state logic. Every register holds unless this process assigns it.
  always_comb begin
    state_d     = state_q;
    coef_addr_d = coef_addr_q;
    tap_cnt_d   = tap_cnt_q;
    ovr_d       = ovr_q;
    smp_out_d   = smp_out_q;
    out_vld_d   = 1'b0;
    acc_d       = acc_q;

    case (state_q)
      S_IDLE: begin
        coef_addr_d = '0;
        if (seq) begin
          for (int c = 0; c < NUM_CH; c++) begin
            acc_d[c] = '0;
          end
          tap_cnt_d   = '0;
          ovr_d       = 1'b0;
          // Address 0 was presented during IDLE, so coef[0] is on coef_in in PRIME.
          coef_addr_d = ADDR_W'(1);
          state_d     = S_PRIME;
        end
      end

      S_PRIME, S_ACC: begin
        if (seq) begin
          state_d = S_ACC;
          if (tap_cnt_q == MAX_TAPS) begin
            // Once the ROM is exhausted, further samples are dropped and the pass is marked.
            ovr_d       = 1'b1;
            coef_addr_d = '0;
          end else begin
            for (int c = 0; c < NUM_CH; c++) begin
              acc_d[c] = acc_q[c] + prod_ext[c];
            end
            tap_cnt_d   = tap_cnt_q + 1'b1;
            coef_addr_d = coef_addr_q + 1'b1;
          end
        end else begin
          coef_addr_d = '0;
          state_d     = S_OUT;
        end
      end

      S_OUT: begin
        for (int c = 0; c < NUM_CH; c++) begin
          smp_out_d[c*DATA_W +: DATA_W] = sat[c];
        end
        out_vld_d   = 1'b1;
        coef_addr_d = '0;
        state_d     = S_IDLE;
      end

      default: begin
        coef_addr_d = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      coef_addr_q <= '0;
      tap_cnt_q   <= '0;
      ovr_q       <= 1'b0;
      smp_out_q   <= '0;
      out_vld_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      coef_addr_q <= coef_addr_d;
      tap_cnt_q   <= tap_cnt_d;
      ovr_q       <= ovr_d;
      smp_out_q   <= smp_out_d;
      out_vld_q   <= out_vld_d;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

  assign coef_addr = coef_addr_q;
  assign tap_cnt   = tap_cnt_q;
  assign ovr       = ovr_q;
  assign smp_out   = smp_out_q;
  assign out_vld   = out_vld_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fir_mac_nch.sv
// tb_fir_mac_nch: directed bench for fir_mac_nch with ADDR_W=3 (an 8-entry ROM).
// The coefficient ROM is modelled as a one-cycle registered lookup.
// All expected values are hand-computed constants.

module tb_fir_mac_nch;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ADDR_W = 3;

`ifdef FIR_MAC_ROUND_EN
  localparam logic [15:0] EXP_IMP = 16'h4000;
`else
  localparam logic [15:0] EXP_IMP = 16'h3FFF;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     seq;
  logic [NUM_CH*DATA_W-1:0] smp_in;
  logic [ADDR_W-1:0]        coef_addr;
  logic [COEF_W-1:0]        coef_in;
  logic [NUM_CH*DATA_W-1:0] smp_out;
  logic                     out_vld;
  logic                     busy;
  logic [ADDR_W:0]          tap_cnt;
  logic                     ovr;

  logic [15:0] rom [0:7];
  logic [15:0] s0  [0:15];
  logic [15:0] s1  [0:15];

  int checks   = 0;
  int failures = 0;
  int lat;
  int pulses;

  always #5 clk = ~clk;

  always @(posedge clk) coef_in <= rom[coef_addr];

  fir_mac_nch #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seq       (seq),
    .smp_in    (smp_in),
    .coef_addr (coef_addr),
    .coef_in   (coef_in),
    .smp_out   (smp_out),
    .out_vld   (out_vld),
    .busy      (busy),
    .tap_cnt   (tap_cnt),
    .ovr       (ovr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] c, input logic [15:0] v0, input logic [15:0] v1);
    for (int i = 0; i < 8; i++) rom[i] = c;
    for (int i = 0; i < 16; i++) begin
      s0[i] = v0;
      s1[i] = v1;
    end
  endtask

  // Holds seq high for n cycles. The first cycle is the IDLE start cycle, and the
  // remaining cycles carry samples 0..n-2. The task returns in the first seq-low cycle.
  task automatic drive(input int n);
    seq    = 1'b1;
    smp_in = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) smp_in = {s1[i-1], s0[i-1]};
      step();
    end
    seq    = 1'b0;
    smp_in = '0;
  endtask

  // Returns the number of cycles from the current cycle to the out_vld pulse, or -1 if no pulse arrives.
  task automatic wait_vld(output int l);
    l = -1;
    for (int k = 0; k < 8; k++) begin
      if (out_vld) begin
        l = k;
        break;
      end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    seq    = 1'b0;
    smp_in = '0;
    fill(16'h0000, 16'h0000, 16'h0000);
    step();
    step();
    chk("rst_smp_out", 32'(smp_out), 32'h0);
    chk("rst_out_vld", 32'(out_vld), 32'h0);
    chk("rst_tap_cnt", 32'(tap_cnt), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_coef_addr", 32'(coef_addr), 32'h0);
    rst_n = 1'b1;
    step();

    // Unit impulse through 4 taps.
    fill(16'h0000, 16'h0000, 16'h0000);
    rom[0] = 16'h4000; rom[1] = 16'h2000; rom[2] = 16'h1000; rom[3] = 16'h0800;
    s0[0] = 16'h7FFF;
    drive(5);
    chk("imp_busy", 32'(busy), 32'h1);
    wait_vld(lat);
    chk("imp_latency", 32'(lat), 32'd2);
    chk("imp_ch0", 32'(smp_out[15:0]), 32'(EXP_IMP));
    chk("imp_ch1", 32'(smp_out[31:16]), 32'h0);
    chk("imp_tap_cnt", 32'(tap_cnt), 32'd4);
    chk("imp_ovr", 32'(ovr), 32'h0);
    step();
    chk("imp_pulse_end", 32'(out_vld), 32'h0);
    chk("imp_idle", 32'(busy), 32'h0);

    // Positive saturation over exactly 8 taps.
    fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
    drive(9);
    wait_vld(lat);
    chk("psat_latency", 32'(lat), 32'd2);
    chk("psat_ch0", 32'(smp_out[15:0]), 32'h7FFF);
    chk("psat_ch1", 32'(smp_out[31:16]), 32'h7FFF);
    chk("psat_tap_cnt", 32'(tap_cnt), 32'd8);
    chk("psat_ovr", 32'(ovr), 32'h0);

    // Negative saturation.
    fill(16'h7FFF, 16'h8000, 16'h8000);
    drive(9);
    wait_vld(lat);
    chk("nsat_latency", 32'(lat), 32'd2);
    chk("nsat_ch0", 32'(smp_out[15:0]), 32'h8000);
    chk("nsat_ch1", 32'(smp_out[31:16]), 32'h8000);

    // Reset after 3 taps aborts the pass.
    step();
    seq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp_in = (i > 0) ? {s1[i-1], s0[i-1]} : '0;
      step();
    end
    chk("rmid_tap_pre", 32'(tap_cnt), 32'd3);
    rst_n = 1'b0;
    step();
    rst_n  = 1'b1;
    seq    = 1'b0;
    smp_in = '0;
    chk("rmid_smp_out", 32'(smp_out), 32'h0);
    chk("rmid_tap_cnt", 32'(tap_cnt), 32'h0);
    chk("rmid_busy", 32'(busy), 32'h0);
    chk("rmid_ovr", 32'(ovr), 32'h0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_vld) pulses++;
      step();
    end
    chk("rmid_no_vld", 32'(pulses), 32'd0);

    // A 2-tap pass after the reset.
    fill(16'h0000, 16'h0000, 16'h0000);
    rom[0] = 16'h4000; rom[1] = 16'h2000;
    s0[0] = 16'h1000; s0[1] = 16'h2000;
    s1[0] = 16'hF000; s1[1] = 16'h0000;
    drive(3);
    wait_vld(lat);
    chk("two_latency", 32'(lat), 32'd2);
    chk("two_ch0", 32'(smp_out[15:0]), 32'h1000);
    chk("two_ch1", 32'(smp_out[31:16]), 32'hF800);
    chk("two_tap_cnt", 32'(tap_cnt), 32'd2);
    step();

    // Overrun: 9 samples arrive for an 8-entry ROM.
    fill(16'h0100, 16'h0100, 16'h0100);
    drive(10);
    wait_vld(lat);
    chk("ovr_latency", 32'(lat), 32'd2);
    chk("ovr_tap_cnt", 32'(tap_cnt), 32'd8);
    chk("ovr_flag", 32'(ovr), 32'h1);
    chk("ovr_ch0", 32'(smp_out[15:0]), 32'h0010);
    chk("ovr_ch1", 32'(smp_out[31:16]), 32'h0010);
    step();

    // Zero-length pass. The pass start clears ovr, and the result is zero.
    seq = 1'b1;
    step();
    seq = 1'b0;
    chk("zl_ovr_clr", 32'(ovr), 32'h0);
    chk("zl_busy", 32'(busy), 32'h1);
    wait_vld(lat);
    chk("zl_latency", 32'(lat), 32'd2);
    chk("zl_tap_cnt", 32'(tap_cnt), 32'd0);
    chk("zl_smp_out", 32'(smp_out), 32'h0);
    step();

    // seq is ignored in OUT, and a pass may restart in the first IDLE cycle.
    fill(16'h0000, 16'h0000, 16'h0000);
    rom[0] = 16'h4000; rom[1] = 16'h2000;
    s0[0] = 16'h1000; s0[1] = 16'h2000;
    s1[0] = 16'hF000;
    drive(3);
    step();
    seq = 1'b1;
    step();
    seq = 1'b0;
    chk("b2b_vld", 32'(out_vld), 32'h1);
    step();
    chk("b2b_out_seq_ignored", 32'(busy), 32'h0);
    chk("b2b_first", 32'(smp_out), {16'hF800, 16'h1000});
    drive(3);
    step();
    step();
    chk("b2b_vld2", 32'(out_vld), 32'h1);
    s0[0] = 16'h2000;
    s1[0] = 16'h0000;
    drive(3);
    wait_vld(lat);
    chk("b2b_restart_latency", 32'(lat), 32'd2);
    chk("b2b_restart_ch0", 32'(smp_out[15:0]), 32'h1800);
    chk("b2b_restart_ch1", 32'(smp_out[31:16]), 32'h0000);
    chk("b2b_restart_tap", 32'(tap_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
